// File: rtl/pll_pkg.sv
// pll_pkg: shared lock-detector state encoding, default tolerances and helpers.
package pll_pkg;

   typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} lock_state_t;

   localparam int unsigned DEF_CNT_W        = 12;
   localparam int unsigned DEF_FREQ_TOL     = 2;
   localparam int unsigned DEF_PHASE_TOL    = 2;
   localparam int unsigned DEF_LOCK_COUNT   = 8;
   localparam int unsigned DEF_UNLOCK_COUNT = 3;

   function automatic int unsigned abs_diff(input int unsigned a, input int unsigned b);
      return (a > b) ? a - b : b - a;
   endfunction

endpackage

// File: rtl/pll_edge_detector.sv
// pll_edge_detector: registers an asynchronous clock input and flags its rising edges.
module pll_edge_detector (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic rise
);

   logic s_q, s_d, p_q, p_d;

   always_comb begin
      s_d = din;
      p_d = s_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_q <= 1'b0;
         p_q <= 1'b0;
      end else begin
         s_q <= s_d;
         p_q <= p_d;
      end
   end

   assign rise = s_q & ~p_q;

endmodule

// File: rtl/pll_lock_detector.sv
// pll_lock_detector: measures ref/fb periods and ref->fb lag in clk cycles and
// qualifies PLL lock over consecutive in-tolerance reference windows.
module pll_lock_detector
   import pll_pkg::*;
#(
   parameter int unsigned CNT_W        = DEF_CNT_W,
   parameter int unsigned FREQ_TOL     = DEF_FREQ_TOL,
   parameter int unsigned PHASE_TOL    = DEF_PHASE_TOL,
   parameter int unsigned LOCK_COUNT   = DEF_LOCK_COUNT,
   parameter int unsigned UNLOCK_COUNT = DEF_UNLOCK_COUNT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             reference_clk_digital,
   input  logic             feedback_clk_digital,
   output logic             lock_digital,
   output logic             lock_lost_digital,
   output logic [CNT_W-1:0] ref_period_real,
   output logic [CNT_W-1:0] fb_period_real,
   output logic [CNT_W-1:0] phase_lag_real
);

   localparam logic [CNT_W-1:0] MAX = '1;
   localparam int GW = $clog2(LOCK_COUNT) + 1;
   localparam int BW = $clog2(UNLOCK_COUNT) + 1;

   logic ref_edge, fb_edge, good, ref_sat;
   logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d, fb_cnt_q, fb_cnt_d, ref_meas, fb_meas;
   logic [CNT_W-1:0] ref_per_q, ref_per_d, fb_per_q, fb_per_d, lag_q, lag_d;
   logic [1:0] fb_edges_q, fb_edges_d;
   logic [GW-1:0] good_cnt_q, good_cnt_d;
   logic [BW-1:0] bad_cnt_q, bad_cnt_d;
   logic lock_q, lock_d, lost_q, lost_d;
   lock_state_t state_q, state_d;

   pll_edge_detector u_ref_edge (.clk(clk), .reset(reset), .din(reference_clk_digital), .rise(ref_edge));
   pll_edge_detector u_fb_edge  (.clk(clk), .reset(reset), .din(feedback_clk_digital),  .rise(fb_edge));

   always_comb begin
      ref_meas   = (ref_cnt_q == MAX) ? MAX : ref_cnt_q + 1'b1;
      fb_meas    = (fb_cnt_q == MAX) ? MAX : fb_cnt_q + 1'b1;
      ref_cnt_d  = ref_edge ? '0 : ref_meas;
      fb_cnt_d   = fb_edge ? '0 : fb_meas;
      ref_sat    = ref_cnt_d == MAX;
      ref_per_d  = ref_edge ? ref_meas : ref_per_q;
      fb_per_d   = fb_edge ? fb_meas : fb_per_q;
      lag_d      = fb_edge ? ref_cnt_d : lag_q;
      // a fb edge coincident with a ref edge is counted in the window it opens
      fb_edges_d = ref_edge ? {1'b0, fb_edge} :
                   (fb_edge && fb_edges_q != 2'd2) ? fb_edges_q + 2'd1 : fb_edges_q;
      good = (fb_edges_q == 2'd1) && (fb_cnt_q != MAX) &&
             (abs_diff(32'(ref_meas), 32'(fb_per_d)) <= FREQ_TOL) &&
             ((32'(lag_q) <= PHASE_TOL) || (32'(lag_q) + PHASE_TOL >= 32'(ref_meas)));
      state_d    = state_q;
      good_cnt_d = good_cnt_q;
      bad_cnt_d  = bad_cnt_q;
      lost_d     = 1'b0;
      if (ref_sat) begin
         state_d    = UNLOCKED;
         good_cnt_d = '0;
         bad_cnt_d  = '0;
         lost_d     = state_q == LOCKED;
      end else if (ref_edge) begin
         if (state_q == UNLOCKED) begin
            state_d    = ACQUIRE;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
         end else if (state_q == ACQUIRE) begin
            good_cnt_d = good ? good_cnt_q + 1'b1 : '0;
            if (good_cnt_d == GW'(LOCK_COUNT)) begin
               state_d   = LOCKED;
               bad_cnt_d = '0;
            end
         end else begin
            bad_cnt_d = good ? '0 : bad_cnt_q + 1'b1;
            if (bad_cnt_d == BW'(UNLOCK_COUNT)) begin
               state_d    = ACQUIRE;
               good_cnt_d = '0;
               lost_d     = 1'b1;
            end
         end
      end
      lock_d = state_d == LOCKED;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ref_cnt_q  <= '0;
         fb_cnt_q   <= '0;
         ref_per_q  <= '0;
         fb_per_q   <= '0;
         lag_q      <= '0;
         fb_edges_q <= '0;
         good_cnt_q <= '0;
         bad_cnt_q  <= '0;
         state_q    <= UNLOCKED;
         lock_q     <= 1'b0;
         lost_q     <= 1'b0;
      end else begin
         ref_cnt_q  <= ref_cnt_d;
         fb_cnt_q   <= fb_cnt_d;
         ref_per_q  <= ref_per_d;
         fb_per_q   <= fb_per_d;
         lag_q      <= lag_d;
         fb_edges_q <= fb_edges_d;
         good_cnt_q <= good_cnt_d;
         bad_cnt_q  <= bad_cnt_d;
         state_q    <= state_d;
         lock_q     <= lock_d;
         lost_q     <= lost_d;
      end
   end

   assign lock_digital      = lock_q;
   assign lock_lost_digital = lost_q;
   assign ref_period_real   = ref_per_q;
   assign fb_period_real    = fb_per_q;
   assign phase_lag_real    = lag_q;

endmodule

// File: tb/tb_pll_lock_detector.sv
// tb_pll_lock_detector: directed lock/unlock scenarios with hand-computed expectations.
module tb_pll_lock_detector;

   logic clk = 1'b0, reset = 1'b1, ref_clk = 1'b0, fb_clk = 1'b0;
   logic lock_digital, lock_lost_digital;
   logic [11:0] ref_period_real, fb_period_real, phase_lag_real;
   int t = 0, fper = 20, fdel = 0, checks = 0, errors = 0, lost_cnt = 0;
   bit ref_en = 1'b1, fb_en = 1'b1, lock_seen = 1'b0;

   pll_lock_detector #(.CNT_W(12), .FREQ_TOL(1), .PHASE_TOL(1), .LOCK_COUNT(4), .UNLOCK_COUNT(2)) dut (
      .clk(clk), .reset(reset),
      .reference_clk_digital(ref_clk), .feedback_clk_digital(fb_clk),
      .lock_digital(lock_digital), .lock_lost_digital(lock_lost_digital),
      .ref_period_real(ref_period_real), .fb_period_real(fb_period_real),
      .phase_lag_real(phase_lag_real)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ref period 20 (high 10), fb period fper delayed by fdel cycles
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (lock_lost_digital) lost_cnt++;
         if (lock_digital) lock_seen = 1'b1;
         ref_clk = ref_en && ((t % 20) < 10);
         fb_clk  = fb_en && (((t + fper - fdel) % fper) < fper / 2);
         t++;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      ref_clk = 1'b0;
      fb_clk = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      t = 0;
      lock_seen = 1'b0;
      lost_cnt = 0;
   endtask

   // 5th ref rise driven at index 80: edge seen in cycle 81, lock visible at 82
   task automatic lock_aligned();
      fper = 20;
      fdel = 0;
      run(82);
      chk("pre_lock", 32'(lock_seen), 0);
      run(1);
      chk("lock_at_edge5", 32'(lock_digital), 1);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_lock", 32'(lock_digital), 0);
      chk("rst_lost", 32'(lock_lost_digital), 0);
      chk("rst_ref_per", 32'(ref_period_real), 0);
      chk("rst_fb_per", 32'(fb_period_real), 0);
      chk("rst_lag", 32'(phase_lag_real), 0);

      do_reset();
      lock_aligned();
      chk("aligned_ref_per", 32'(ref_period_real), 20);
      chk("aligned_fb_per", 32'(fb_period_real), 20);
      chk("aligned_lag", 32'(phase_lag_real), 0);

      fper = 24;
      lost_cnt = 0;
      run(200);
      chk("step24_lost_pulses", 32'(lost_cnt), 1);
      chk("step24_lock", 32'(lock_digital), 0);

      do_reset();
      fper = 20; fdel = 1;
      run(300);
      chk("lag1_lock", 32'(lock_digital), 1);
      chk("lag1_lag", 32'(phase_lag_real), 1);

      do_reset();
      fdel = 3;
      run(300);
      chk("lag3_never_lock", 32'(lock_seen), 0);
      chk("lag3_lag", 32'(phase_lag_real), 3);

      do_reset();
      fdel = 19;
      run(300);
      chk("lag19_lock", 32'(lock_digital), 1);
      chk("lag19_lag", 32'(phase_lag_real), 19);

      do_reset();
      fdel = 0; fb_en = 1'b0;
      run(300);
      chk("fb_low_never_lock", 32'(lock_seen), 0);
      fb_en = 1'b1;

      do_reset();
      fper = 10;
      run(300);
      chk("fb_double_never_lock", 32'(lock_seen), 0);
      chk("fb_double_fb_per", 32'(fb_period_real), 10);

      do_reset();
      lock_aligned();
      ref_en = 1'b0;
      lost_cnt = 0;
      run(4000);
      chk("ref_stop_still_locked", 32'(lock_digital), 1);
      run(200);
      chk("ref_stop_lost_pulses", 32'(lost_cnt), 1);
      chk("ref_stop_lock", 32'(lock_digital), 0);
      ref_en = 1'b1;

      do_reset();
      lock_aligned();
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_lock", 32'(lock_digital), 0);
      chk("async_rst_ref_per", 32'(ref_period_real), 0);
      chk("async_rst_fb_per", 32'(fb_period_real), 0);
      lost_cnt = 0;
      repeat (3) begin
         @(negedge clk);
         if (lock_lost_digital) lost_cnt++;
      end
      chk("async_rst_no_lost", 32'(lost_cnt), 0);
      do_reset();
      lock_aligned();
      chk("relock_no_lost", 32'(lost_cnt), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
